// File: rtl/ccip_rd_arbiter_if.sv
// rtl/ccip_rd_arbiter_if.sv - signal bundle between read engines, the c0 channel and the arbiter
interface ccip_rd_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 42
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*12-1:0]     req_tag;
  logic [N_REQ-1:0]        req_ready;
  logic                    c0tx_valid;
  logic [ADDR_W-1:0]       c0tx_addr;
  logic [15:0]             c0tx_mdata;
  logic                    c0_alm_full;
  logic                    c0rx_valid;
  logic [15:0]             c0rx_mdata;
  logic [511:0]            c0rx_data;
  logic [N_REQ-1:0]        resp_valid;
  logic [11:0]             resp_tag;
  logic [511:0]            resp_data;
  logic                    outstanding_any;
  logic                    err_sticky;

  // Arbiter side
  modport master (
    input  req_valid, req_addr, req_tag, c0_alm_full, c0rx_valid, c0rx_mdata, c0rx_data,
    output req_ready, c0tx_valid, c0tx_addr, c0tx_mdata, resp_valid, resp_tag, resp_data,
           outstanding_any, err_sticky
  );

  // Requester / host side
  modport slave (
    output req_valid, req_addr, req_tag, c0_alm_full, c0rx_valid, c0rx_mdata, c0rx_data,
    input  req_ready, c0tx_valid, c0tx_addr, c0tx_mdata, resp_valid, resp_tag, resp_data,
           outstanding_any, err_sticky
  );
endinterface

// File: rtl/ccip_rd_arbiter.sv
// rtl/ccip_rd_arbiter.sv - round-robin sharing of the CCI-P c0 read channel with per-requester credits
module ccip_rd_arbiter #(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W          = 42
) (
  input  logic              clk,
  input  logic              reset,
  ccip_rd_arbiter_if.master bus
);

  localparam int               CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [3:0]       LAST_ID   = 4'(N_REQ - 1);

  // State
  logic [3:0]        rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q [N_REQ];
  logic [CNT_W-1:0]  cnt_d [N_REQ];
  logic              err_q, err_d;
  logic              c0tx_valid_q;
  logic [ADDR_W-1:0] c0tx_addr_q;
  logic [15:0]       c0tx_mdata_q;
  logic [N_REQ-1:0]  resp_valid_q;
  logic [11:0]       resp_tag_q;
  logic [511:0]      resp_data_q;
  logic              outstanding_q;

  // Combinational
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  rotated;
  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  logic [3:0]        grant_id;
  logic [4:0]        grant_sum;
  logic [ADDR_W-1:0] sel_addr;
  logic [11:0]       sel_tag;
  logic [3:0]        rsp_id;
  logic              rsp_bad;
  logic [N_REQ-1:0]  rsp_hit;
  logic              underflow;
  logic              any_nz;

  // A requester may compete only while it still has read credits left
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (cnt_q[i] < CNT_LIMIT);
    end
  end

  // Rotate eligibility so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    rotated   = N_REQ'({eligible, eligible} >> rr_q);
    grant_any = 1'b0;
    grant_id  = '0;
    grant_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        grant_any = 1'b1;
        grant_sum = 5'(rr_q) + 5'(k);
        if (grant_sum >= 5'(N_REQ)) begin
          grant_sum = grant_sum - 5'(N_REQ);
        end
        grant_id = grant_sum[3:0];
      end
    end
    // Host backpressure and reset both block every grant, keeping req_ready at zero
    if (bus.c0_alm_full || reset) begin
      grant_any = 1'b0;
      grant_id  = '0;
    end
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = grant_any && (grant_id == 4'(i));
    end
  end

  // Steer the granted requester's address and tag onto the c0 request
  always_comb begin
    sel_addr = '0;
    sel_tag  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_tag  = bus.req_tag[i*12 +: 12];
      end
    end
  end

  // Decode the owning requester from the upper mdata nibble of a response
  always_comb begin
    rsp_id  = bus.c0rx_mdata[15:12];
    rsp_bad = bus.c0rx_valid && ({1'b0, rsp_id} >= 5'(N_REQ));
    rsp_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_hit[i] = bus.c0rx_valid && (rsp_id == 4'(i));
    end
  end

  // Credit counters, error accumulation and next round-robin pointer
  always_comb begin
    underflow = 1'b0;
    any_nz    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !rsp_hit[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!grant[i] && rsp_hit[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      // A response with nothing outstanding is still delivered, but flagged
      if (rsp_hit[i] && (cnt_q[i] == '0)) begin
        underflow = 1'b1;
      end
      if (cnt_q[i] != '0) begin
        any_nz = 1'b1;
      end
    end
    err_d = err_q | rsp_bad | underflow;
    rr_d  = rr_q;
    if (grant_any) begin
      rr_d = (grant_id == LAST_ID) ? 4'd0 : grant_id + 4'd1;
    end
  end

  // Registered state and outputs; reset drops everything, including in-flight accounting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q          <= '0;
      err_q         <= 1'b0;
      c0tx_valid_q  <= 1'b0;
      c0tx_addr_q   <= '0;
      c0tx_mdata_q  <= '0;
      resp_valid_q  <= '0;
      resp_tag_q    <= '0;
      resp_data_q   <= '0;
      outstanding_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q          <= rr_d;
      err_q         <= err_d;
      c0tx_valid_q  <= grant_any;
      resp_valid_q  <= rsp_hit;
      outstanding_q <= any_nz;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (grant_any) begin
        c0tx_addr_q  <= sel_addr;
        c0tx_mdata_q <= {grant_id, sel_tag};
      end
      if (bus.c0rx_valid && !rsp_bad) begin
        resp_tag_q  <= bus.c0rx_mdata[11:0];
        resp_data_q <= bus.c0rx_data;
      end
    end
  end

  assign bus.req_ready       = grant;
  assign bus.c0tx_valid      = c0tx_valid_q;
  assign bus.c0tx_addr       = c0tx_addr_q;
  assign bus.c0tx_mdata      = c0tx_mdata_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_tag        = resp_tag_q;
  assign bus.resp_data       = resp_data_q;
  assign bus.outstanding_any = outstanding_q;
  assign bus.err_sticky      = err_q;

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// tb/tb_ccip_rd_arbiter.sv - scoreboard bench for ccip_rd_arbiter
module tb_ccip_rd_arbiter;
  localparam int N    = 4;
  localparam int AW   = 42;
  localparam int MAXO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ccip_rd_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

  ccip_rd_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   mdata;
  } tx_t;

  typedef struct packed {
    logic [N-1:0]  onehot;
    logic [11:0]   tag;
    logic [511:0]  data;
  } rx_t;

  tx_t tx_q[$];
  rx_t rx_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model
  int m_rr;
  int m_cnt [N];
  bit m_err;

  logic [N-1:0] rdy, gexp;
  bit           any_exp;
  tx_t          t;
  rx_t          r;

  task automatic idle_inputs();
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_tag     = '0;
    bus.c0_alm_full = 1'b0;
    bus.c0rx_valid  = 1'b0;
    bus.c0rx_mdata  = '0;
    bus.c0rx_data   = '0;
  endtask

  task automatic model_clear();
    m_rr  = 0;
    m_err = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    tx_q.delete();
    rx_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (!bus.c0_alm_full) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (bus.req_valid[i] && m_cnt[i] < MAXO) begin
          g[i] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic rand_reqs(input int tag_base);
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = AW'({$urandom(), $urandom()});
      bus.req_tag[i*12 +: 12]  = 12'(tag_base * 16 + i);
    end
  endtask

  // One clock of stimulus: predict, push expectations, update the model, then step past the edge
  task automatic advance(output logic [N-1:0] rdy_o, output logic [N-1:0] gexp_o, output bit any_o);
    int           id;
    logic [N-1:0] oh;
    rx_t          e;
    #1;
    rdy_o  = bus.req_ready;
    gexp_o = exp_grant();
    any_o  = 0;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) any_o = 1;
    for (int i = 0; i < N; i++) begin
      if (gexp_o[i]) tx_q.push_back('{addr: bus.req_addr[i*AW +: AW], mdata: {4'(i), bus.req_tag[i*12 +: 12]}});
    end
    id = int'(bus.c0rx_mdata[15:12]);
    if (bus.c0rx_valid) begin
      if (id >= N) begin
        m_err = 1;
      end else begin
        oh = '0;
        oh[id] = 1'b1;
        e.onehot = oh;
        e.tag    = bus.c0rx_mdata[11:0];
        e.data   = bus.c0rx_data;
        rx_q.push_back(e);
      end
    end
    for (int i = 0; i < N; i++) begin
      bit hit;
      hit = bus.c0rx_valid && (id == i);
      if (hit && m_cnt[i] == 0) m_err = 1;
      if (gexp_o[i] && !hit) m_cnt[i]++;
      else if (!gexp_o[i] && hit && m_cnt[i] > 0) m_cnt[i]--;
    end
    for (int i = 0; i < N; i++) if (gexp_o[i]) m_rr = (i + 1) % N;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.req_valid = '1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.c0tx_valid, bus.c0tx_addr, bus.c0tx_mdata, bus.resp_valid, bus.resp_tag,
         bus.outstanding_any, bus.err_sticky} !== '0 || bus.resp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b c0tx_valid=%b mdata=%h resp_valid=%b any=%b err=%b required all zero",
               bus.req_ready, bus.c0tx_valid, bus.c0tx_mdata, bus.resp_valid, bus.outstanding_any, bus.err_sticky);
    end
    reset = 1'b0;
    bus.req_valid = '0;
    model_clear();
  endtask

  task automatic test_round_robin();
    bus.req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      rand_reqs(c);
      advance(rdy, gexp, any_exp);
      n_cmp++;
      if (rdy !== gexp || rdy !== 4'(1 << (c % 4))) begin
        n_fail++;
        $display("FAIL rr_grant cyc=%0d: got %b required %b", c, rdy, 4'(1 << (c % 4)));
      end
      t = tx_q.pop_front();
      n_cmp++;
      if ({bus.c0tx_valid, bus.c0tx_addr, bus.c0tx_mdata} !== {1'b1, t.addr, t.mdata} || bus.c0tx_mdata[15:12] !== 4'(c % 4)) begin
        n_fail++;
        $display("FAIL rr_c0tx cyc=%0d: got v=%b mdata=%h required v=1 mdata=%h", c, bus.c0tx_valid, bus.c0tx_mdata, t.mdata);
      end
    end
    bus.req_valid = '0;
    advance(rdy, gexp, any_exp);
    n_cmp++;
    if (bus.c0tx_valid !== 1'b0 || bus.outstanding_any !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_idle: got c0tx_valid=%b any=%b required 0 1", bus.c0tx_valid, bus.outstanding_any);
    end
  endtask

  task automatic test_responses();
    int order [8] = '{3, 0, 2, 1, 0, 1, 2, 3};
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        bus.c0rx_valid = 1'b1;
        bus.c0rx_mdata = {4'(order[k]), 12'($urandom())};
        bus.c0rx_data  = {16{$urandom()}};
      end else begin
        bus.c0rx_valid = 1'b0;
      end
      advance(rdy, gexp, any_exp);
      n_cmp++;
      if (rx_q.size() != 0) begin
        r = rx_q.pop_front();
        if ({bus.resp_valid, bus.resp_tag, bus.resp_data} !== {r.onehot, r.tag, r.data}) begin
          n_fail++;
          $display("FAIL resp_route k=%0d: got v=%b tag=%h required v=%b tag=%h", k, bus.resp_valid, bus.resp_tag, r.onehot, r.tag);
        end
      end else if (bus.resp_valid !== '0) begin
        n_fail++;
        $display("FAIL resp_idle k=%0d: got v=%b required 0", k, bus.resp_valid);
      end
      n_cmp++;
      if (bus.outstanding_any !== any_exp || bus.err_sticky !== 1'b0) begin
        n_fail++;
        $display("FAIL resp_flags k=%0d: got any=%b err=%b required any=%b err=0", k, bus.outstanding_any, bus.err_sticky, any_exp);
      end
    end
    advance(rdy, gexp, any_exp);
    n_cmp++;
    if (bus.outstanding_any !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_drained: got any=%b required 0", bus.outstanding_any);
    end
  endtask

  task automatic test_alm_full();
    logic [N-1:0] exp_seq [3] = '{4'b0010, 4'b1000, 4'b0000};
    do_reset();
    rand_reqs(1);
    bus.req_valid   = 4'b1010;
    bus.c0_alm_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      advance(rdy, gexp, any_exp);
      n_cmp++;
      if (rdy !== 4'b0000 || bus.c0tx_valid !== 1'b0 || tx_q.size() != 0) begin
        n_fail++;
        $display("FAIL almfull_block cyc=%0d: got rdy=%b c0tx_valid=%b required 0 0", c, rdy, bus.c0tx_valid);
      end
    end
    bus.c0_alm_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      advance(rdy, gexp, any_exp);
      bus.req_valid = bus.req_valid & ~gexp;
      n_cmp++;
      if (rdy !== exp_seq[c] || rdy !== gexp) begin
        n_fail++;
        $display("FAIL almfull_grant cyc=%0d: got %b required %b", c, rdy, exp_seq[c]);
      end
      n_cmp++;
      if (tx_q.size() != 0) begin
        t = tx_q.pop_front();
        if ({bus.c0tx_valid, bus.c0tx_addr, bus.c0tx_mdata} !== {1'b1, t.addr, t.mdata}) begin
          n_fail++;
          $display("FAIL almfull_c0tx cyc=%0d: got v=%b mdata=%h required v=1 mdata=%h", c, bus.c0tx_valid, bus.c0tx_mdata, t.mdata);
        end
      end else if (bus.c0tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL almfull_dup cyc=%0d: got c0tx_valid=%b required 0", c, bus.c0tx_valid);
      end
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    bus.req_valid = 4'b0100;
    for (int c = 0; c < MAXO; c++) begin
      rand_reqs(c);
      advance(rdy, gexp, any_exp);
      t = tx_q.pop_front();
      n_cmp++;
      if (rdy !== 4'b0100 || {bus.c0tx_valid, bus.c0tx_addr, bus.c0tx_mdata} !== {1'b1, t.addr, t.mdata}) begin
        n_fail++;
        $display("FAIL credit_issue cyc=%0d: got rdy=%b mdata=%h required rdy=0100 mdata=%h", c, rdy, bus.c0tx_mdata, t.mdata);
      end
    end
    advance(rdy, gexp, any_exp);
    n_cmp++;
    if (rdy !== 4'b0000 || bus.c0tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_full: got rdy=%b c0tx_valid=%b required 0 0", rdy, bus.c0tx_valid);
    end
    bus.c0rx_valid = 1'b1;
    bus.c0rx_mdata = 16'h2ABC;
    bus.c0rx_data  = {16{$urandom()}};
    advance(rdy, gexp, any_exp);
    bus.c0rx_valid = 1'b0;
    r = rx_q.pop_front();
    n_cmp++;
    if (rdy !== 4'b0000 || bus.resp_valid !== 4'b0100 || bus.resp_tag !== 12'hABC || bus.resp_data !== r.data) begin
      n_fail++;
      $display("FAIL credit_resp: got rdy=%b resp_valid=%b tag=%h required rdy=0000 resp_valid=0100 tag=abc", rdy, bus.resp_valid, bus.resp_tag);
    end
    advance(rdy, gexp, any_exp);
    t = tx_q.pop_front();
    n_cmp++;
    if (rdy !== 4'b0100 || bus.c0tx_valid !== 1'b1 || bus.c0tx_mdata !== t.mdata || bus.resp_valid !== '0) begin
      n_fail++;
      $display("FAIL credit_return: got rdy=%b c0tx_valid=%b required rdy=0100 c0tx_valid=1", rdy, bus.c0tx_valid);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      rand_reqs(c);
      advance(rdy, gexp, any_exp);
      void'(tx_q.pop_front());
    end
    bus.c0rx_valid = 1'b1;
    bus.c0rx_mdata = 16'h0123;
    bus.c0rx_data  = {16{$urandom()}};
    advance(rdy, gexp, any_exp);
    bus.c0rx_valid = 1'b0;
    bus.req_valid  = '0;
    t = tx_q.pop_front();
    r = rx_q.pop_front();
    n_cmp++;
    if (rdy !== 4'b0001 || bus.c0tx_mdata !== t.mdata || bus.resp_valid !== 4'b0001 || bus.resp_tag !== 12'h123) begin
      n_fail++;
      $display("FAIL same_cycle_io: got rdy=%b resp_valid=%b tag=%h required 0001 0001 123", rdy, bus.resp_valid, bus.resp_tag);
    end
    n_cmp++;
    if (dut.cnt_q[0] !== 7'd5 || m_cnt[0] != 5 || bus.err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_cnt: got cnt0=%0d err=%b required 5 0", dut.cnt_q[0], bus.err_sticky);
    end
  endtask

  task automatic test_errors();
    do_reset();
    bus.c0rx_valid = 1'b1;
    bus.c0rx_mdata = 16'h7001;
    bus.c0rx_data  = {16{$urandom()}};
    advance(rdy, gexp, any_exp);
    bus.c0rx_valid = 1'b0;
    n_cmp++;
    if (bus.resp_valid !== '0 || bus.err_sticky !== 1'b1 || m_err != 1 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_id: got resp_valid=%b err=%b required 0000 1", bus.resp_valid, bus.err_sticky);
    end
    advance(rdy, gexp, any_exp);
    n_cmp++;
    if (bus.err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky_hold: got %b required 1", bus.err_sticky);
    end
    do_reset();
    n_cmp++;
    if (bus.err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: got %b required 0", bus.err_sticky);
    end
    bus.c0rx_valid = 1'b1;
    bus.c0rx_mdata = 16'h1000;
    bus.c0rx_data  = {16{$urandom()}};
    advance(rdy, gexp, any_exp);
    bus.c0rx_valid = 1'b0;
    r = rx_q.pop_front();
    n_cmp++;
    if (bus.resp_valid !== 4'b0010 || bus.resp_tag !== 12'h000 || bus.resp_data !== r.data ||
        bus.err_sticky !== 1'b1 || dut.cnt_q[1] !== 7'd0) begin
      n_fail++;
      $display("FAIL underflow: got resp_valid=%b err=%b cnt1=%0d required 0010 1 0", bus.resp_valid, bus.err_sticky, dut.cnt_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_seq [2] = '{4'b0001, 4'b0010};
    do_reset();
    bus.req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      rand_reqs(c);
      advance(rdy, gexp, any_exp);
      t = tx_q.pop_front();
      n_cmp++;
      if (rdy !== gexp || bus.c0tx_mdata !== t.mdata) begin
        n_fail++;
        $display("FAIL mid_issue cyc=%0d: got rdy=%b mdata=%h required rdy=%b mdata=%h", c, rdy, bus.c0tx_mdata, gexp, t.mdata);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.c0tx_valid, bus.c0tx_addr, bus.c0tx_mdata, bus.resp_valid, bus.resp_tag,
         bus.outstanding_any, bus.err_sticky} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rdy=%b c0tx_valid=%b mdata=%h any=%b required all zero",
               bus.req_ready, bus.c0tx_valid, bus.c0tx_mdata, bus.outstanding_any);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (dut.cnt_q[i] !== 7'd0) begin
        n_fail++;
        $display("FAIL mid_reset_cnt%0d: got %0d required 0", i, dut.cnt_q[i]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      rand_reqs(20 + c);
      advance(rdy, gexp, any_exp);
      t = tx_q.pop_front();
      n_cmp++;
      if (rdy !== exp_seq[c] || rdy !== gexp || bus.c0tx_mdata !== t.mdata) begin
        n_fail++;
        $display("FAIL mid_restart cyc=%0d: got rdy=%b required %b", c, rdy, exp_seq[c]);
      end
    end
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_responses();
    test_alm_full();
    test_credit_limit();
    test_same_cycle();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
